// File: rtl/frogger_pkg.sv
// Shared types and helpers for the Frogger score display path.
// Scores are packed BCD vectors with digit 0 (units) in the low nibble.
package frogger_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX    = 4'd9;
   localparam int   MAX_DIGITS = 8;

   // Callers zero-extend narrower scores; leading zero digits keep the numeric order intact.
   function automatic logic bcd_gt(input logic [4*MAX_DIGITS-1:0] a,
                                   input logic [4*MAX_DIGITS-1:0] b);
      logic gt;
      logic decided;
      bcd_t da;
      bcd_t db;
      gt      = 1'b0;
      decided = 1'b0;
      for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
         da = a[4*i +: 4];
         db = b[4*i +: 4];
         if (!decided && (da != db)) begin
            gt      = (da > db);
            decided = 1'b1;
         end
      end
      return gt;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the score counter: counts 0..9 and ripples a carry to the next decade.
module bcd_digit
   import frogger_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic cin,
   input  logic en,
   output bcd_t q,
   output logic cout
);

   assign cout = cin & (q == BCD_MAX);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= '0;
      end else if (en && cin) begin
         q <= (q == BCD_MAX) ? bcd_t'(0) : bcd_t'(q + 4'd1);
      end
   end

   digit_in_range: assert property (@(posedge clk) disable iff (reset) q <= BCD_MAX);

endmodule

// File: rtl/score_bcd_counter.sv
// Frogger score counter: edge-detected point/game-over events, saturating BCD score,
// high-score register and leading-zero blanking for the per-digit HEX decoders.
module score_bcd_counter
   import frogger_pkg::*;
#(
   parameter int NUM_DIGITS = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    point,
   input  logic                    game_over,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [4*NUM_DIGITS-1:0] hi_digits,
   output logic [NUM_DIGITS-1:0]   blank,
   output logic                    saturated
);

   logic                  point_q;
   logic                  go_q;
   logic                  rise;
   logic                  go_rise;
   logic [NUM_DIGITS:0]   carry;
   logic [4*MAX_DIGITS-1:0] cur_ext;
   logic [4*MAX_DIGITS-1:0] hi_ext;
   logic                  new_high;

   // Edge registers reset high so a level already asserted at reset is not an event.
   always_ff @(posedge clk) begin
      if (reset) begin
         point_q <= 1'b1;
         go_q    <= 1'b1;
      end else begin
         point_q <= point;
         go_q    <= game_over;
      end
   end

   assign rise    = point & ~point_q;
   assign go_rise = game_over & ~go_q;
   assign carry[0] = rise;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk   (clk),
         .reset (reset),
         .clr   (clear),
         .cin   (carry[g]),
         .en    (~saturated),
         .q     (digits[4*g +: 4]),
         .cout  (carry[g+1])
      );
   end

   always_comb begin
      saturated = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digits[4*i +: 4] != BCD_MAX) saturated = 1'b0;
      end
   end

   // Walk from the MSD down; a digit is blankable while everything above it is zero.
   always_comb begin
      logic any_nz;
      any_nz = 1'b0;
      blank  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         any_nz   = any_nz | (digits[4*i +: 4] != 4'd0);
         blank[i] = (i > 0) && !any_nz;
      end
   end

   always_comb begin
      cur_ext = '0;
      hi_ext  = '0;
      cur_ext[4*NUM_DIGITS-1:0] = digits;
      hi_ext[4*NUM_DIGITS-1:0]  = hi_digits;
      new_high = bcd_gt(cur_ext, hi_ext);
   end

   // Commits the registered (pre-increment, pre-clear) score.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_digits <= '0;
      end else if (go_rise && new_high) begin
         hi_digits <= digits;
      end
   end

   msd_carry_only_when_full: assert property (@(posedge clk) disable iff (reset)
      carry[NUM_DIGITS] |-> saturated);

endmodule
